// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-port SRAM access controller shared by fetch and MEM stage
//
// Purpose:
//   Fetches at i_if_addr every cycle. A MEM-stage load/store replaces the fetch
//   with a data access; o_ram_pause holds the front of the pipeline meanwhile.
//   Optional feature macro: MEM_WR_HOLD_EN (adds a HOLD state after every write
//   so address/data outlive the rising edge of o_sram_we_n).
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_if_addr/o_if_data  instruction fetch address / fetched word
//   i_mem_rd/i_mem_wr    MEM-stage load/store request levels (write wins if both)
//   i_mem_addr           data address
//   i_mem_wdata          store data
//   o_mem_rdata          registered load result
//   o_ram_pause          high while the SRAM is busy with a data access
//   o_sram_*             SRAM address, write data, drive enable, active-low strobes
//   i_sram_data_i        data read back from the SRAM bus
module mem_access_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_data,
    input  logic              i_mem_rd,
    input  logic              i_mem_wr,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_ram_pause,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_data_o,
    output logic              o_sram_data_oe,
    input  logic [DATA_W-1:0] i_sram_data_i,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n
);

`ifdef MEM_WR_HOLD_EN
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DATA  = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DATA  = 2'd1,
        S_DONE  = 2'd2
    } state_t;
`endif

    localparam logic [2:0] LP_WAIT = 3'(WAIT_CYC);

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_cnt;
    logic [DATA_W-1:0] r_mem_rdata;
    logic [DATA_W-1:0] r_if_data;
    logic              w_req;
    logic              w_last;
    logic              w_fetch;

    assign w_req  = i_mem_rd | i_mem_wr;
    assign w_last = (r_cnt == LP_WAIT);

    always_comb begin
        w_next         = r_state;
        w_fetch        = 1'b0;
        o_sram_addr    = i_if_addr;
        o_sram_data_o  = i_mem_wdata;
        o_sram_data_oe = 1'b0;
        o_sram_ce_n    = 1'b0;
        o_sram_oe_n    = 1'b0;
        o_sram_we_n    = 1'b1;
        o_ram_pause    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_fetch = 1'b1;
                // Pause in the request cycle itself so PC does not advance
                // past the instruction that owns the MEM stage.
                if (w_req) begin
                    o_ram_pause = 1'b1;
                    w_next      = S_DATA;
                end
            end
            S_DATA: begin
                o_sram_addr = i_mem_addr;
                o_ram_pause = 1'b1;
                if (i_mem_wr) begin
                    o_sram_we_n    = 1'b0;
                    o_sram_oe_n    = 1'b1;
                    o_sram_data_oe = 1'b1;
                end
                if (w_last) begin
`ifdef MEM_WR_HOLD_EN
                    w_next = i_mem_wr ? S_HOLD : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef MEM_WR_HOLD_EN
            S_HOLD: begin
                // we_n released while address and data stay on the bus.
                o_sram_addr    = i_mem_addr;
                o_sram_oe_n    = 1'b1;
                o_sram_data_oe = 1'b1;
                o_ram_pause    = 1'b1;
                w_next         = S_DONE;
            end
`endif
            S_DONE: begin
                // Request is still asserted here but belongs to the access just
                // finished; only a request seen back in FETCH starts a new one.
                w_fetch = 1'b1;
                w_next  = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        // Reset forces the bus idle in the reset cycle, aborting any write.
        if (i_rst) begin
            o_sram_ce_n    = 1'b1;
            o_sram_oe_n    = 1'b1;
            o_sram_we_n    = 1'b1;
            o_sram_data_oe = 1'b0;
            o_ram_pause    = 1'b0;
        end
    end

    assign o_if_data   = w_fetch ? i_sram_data_i : r_if_data;
    assign o_mem_rdata = r_mem_rdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_FETCH;
            r_cnt       <= 3'd0;
            r_mem_rdata <= '0;
            r_if_data   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DATA && !w_last) begin
                r_cnt <= r_cnt + 3'd1;
            end else begin
                r_cnt <= 3'd0;
            end
            // A conflicting rd+wr is a write, so it leaves mem_rdata alone.
            if (r_state == S_DATA && w_last && !i_mem_wr) begin
                r_mem_rdata <= i_sram_data_i;
            end
            if (w_fetch) begin
                r_if_data <= i_sram_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard testbench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int WC = 2;
`ifdef MEM_WR_HOLD_EN
    localparam int WR_EXTRA = 1;
`else
    localparam int WR_EXTRA = 0;
`endif

    logic          clk;
    logic          rst;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_data;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          ram_pause;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_data_o;
    logic          sram_data_oe;
    logic [DW-1:0] sram_data_i;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_if_addr     (if_addr),
        .o_if_data     (if_data),
        .i_mem_rd      (mem_rd),
        .i_mem_wr      (mem_wr),
        .i_mem_addr    (mem_addr),
        .i_mem_wdata   (mem_wdata),
        .o_mem_rdata   (mem_rdata),
        .o_ram_pause   (ram_pause),
        .o_sram_addr   (sram_addr),
        .o_sram_data_o (sram_data_o),
        .o_sram_data_oe(sram_data_oe),
        .i_sram_data_i (sram_data_i),
        .o_sram_ce_n   (sram_ce_n),
        .o_sram_oe_n   (sram_oe_n),
        .o_sram_we_n   (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: words never written return a fixed preload pattern.
    logic [DW-1:0] mem      [0:4095];
    bit            mem_vld  [0:4095];

    function automatic logic [DW-1:0] init_word(input logic [11:0] a);
        case (a)
            12'h010: init_word = 16'hA001;
            12'h011: init_word = 16'hA002;
            12'h012: init_word = 16'hA003;
            12'hF00: init_word = 16'h5A5A;
            default: init_word = {4'h0, a} ^ 16'hC3C3;
        endcase
    endfunction

    function automatic logic [DW-1:0] model_rd(input logic [11:0] a);
        model_rd = mem_vld[a] ? mem[a] : init_word(a);
    endfunction

    always_comb begin
        sram_data_i = 16'hDEAD;
        if (!sram_ce_n && !sram_oe_n && !sram_data_oe) begin
            sram_data_i = model_rd(sram_addr[11:0]);
        end
    end

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
            mem[sram_addr[11:0]]     <= sram_data_o;
            mem_vld[sram_addr[11:0]] <= 1'b1;
        end
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic [DW-1:0] q_fetch [$];
    logic [DW-1:0] q_rdata [$];
    wr_t           q_wr    [$];
    logic [DW-1:0] last_rd;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                             input int exp_pause, input int exp_we, input logic [DW-1:0] exp_ifw);
        int  n_pause;
        int  n_we;
        bit  done;
        wr_t w;
        n_pause = 0;
        n_we    = 0;
        done    = 1'b0;
        drive_edge();
        mem_rd    = rd;
        mem_wr    = wr;
        mem_addr  = a;
        mem_wdata = d;
        if (wr) q_wr.push_back('{a: a, d: d});
        else    q_rdata.push_back(exp_rd);
        q_fetch.push_back(exp_ifw);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (ram_pause) begin
                n_pause++;
                if (n_pause == 2) check_val("held_if_data", 32'(if_data), 32'(exp_ifw));
                if (!sram_we_n) begin
                    n_we++;
                    check_val("wr_data_oe", 32'(sram_data_oe), 32'd1);
                    check_val("wr_data_o", 32'(sram_data_o), 32'(d));
                    check_val("wr_addr", 32'(sram_addr), 32'(a));
                end
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check_val("access_timeout", 32'd0, 32'd1);
        check_val("pause_len", 32'(n_pause), 32'(exp_pause));
        check_val("we_low_len", 32'(n_we), 32'(exp_we));
        check_val("done_if_data", 32'(if_data), 32'(q_fetch.pop_front()));
        check_val("done_addr", 32'(sram_addr), 32'(if_addr));
        if (!wr) begin
            last_rd = q_rdata.pop_front();
            check_val("load_rdata", 32'(mem_rdata), 32'(last_rd));
        end
        drive_edge();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        @(negedge clk);
        check_val("fetch_after_pause", 32'(ram_pause), 32'd0);
        check_val("fetch_after_oe_n", 32'(sram_oe_n), 32'd0);
        if (wr) begin
            w = q_wr.pop_front();
            check_val("store_mem", 32'(model_rd(w.a[11:0])), 32'(w.d));
            check_val("rdata_kept", 32'(mem_rdata), 32'(last_rd));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        last_rd   = 16'h0000;
        rst       = 1'b1;
        mem_rd    = 1'b0;
        mem_wr    = 1'b1;
        mem_addr  = 18'h00300;
        mem_wdata = 16'hBEEF;
        if_addr   = 18'h00010;

        // Reset with a pending store: bus must stay idle.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("rst_we_n", 32'(sram_we_n), 32'd1);
            check_val("rst_data_oe", 32'(sram_data_oe), 32'd0);
            check_val("rst_pause", 32'(ram_pause), 32'd0);
            check_val("rst_ce_n", 32'(sram_ce_n), 32'd1);
        end
        drive_edge();
        rst    = 1'b0;
        mem_wr = 1'b0;
        @(negedge clk);
        check_val("post_rst_pause", 32'(ram_pause), 32'd0);
        check_val("post_rst_ce_n", 32'(sram_ce_n), 32'd0);
        check_val("post_rst_oe_n", 32'(sram_oe_n), 32'd0);
        check_val("post_rst_rdata", 32'(mem_rdata), 32'd0);
        check_val("rst_no_write", 32'(mem_vld[12'h300]), 32'd0);

        // Fetch stream, one word per cycle.
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            if_addr = 18'h00010 + 18'(i);
            q_fetch.push_back(16'hA001 + 16'(i));
            @(negedge clk);
            check_val("fetch_word", 32'(if_data), 32'(q_fetch.pop_front()));
            check_val("fetch_pause", 32'(ram_pause), 32'd0);
        end

        // Load, store, conflict (write wins), load-back of the stored word.
        do_access(1'b1, 1'b0, 18'h0BF00, 16'h0000, 16'h5A5A, 2 + WC, 0, 16'hA003);
        do_access(1'b0, 1'b1, 18'h00200, 16'h1234, 16'h0000, 2 + WC + WR_EXTRA, WC + 1, 16'hA003);
        do_access(1'b1, 1'b1, 18'h00201, 16'h4321, 16'h0000, 2 + WC + WR_EXTRA, WC + 1, 16'hA003);
        do_access(1'b1, 1'b0, 18'h00200, 16'h0000, 16'h1234, 2 + WC, 0, 16'hA003);

        // Reset in the middle of a store.
        drive_edge();
        mem_wr    = 1'b1;
        mem_addr  = 18'h00250;
        mem_wdata = 16'h7777;
        @(negedge clk);
        check_val("mid_req_pause", 32'(ram_pause), 32'd1);
        @(negedge clk);
        check_val("mid_data_we_n", 32'(sram_we_n), 32'd0);
        drive_edge();
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_we_n", 32'(sram_we_n), 32'd1);
        check_val("mid_rst_pause", 32'(ram_pause), 32'd0);
        check_val("mid_rst_data_oe", 32'(sram_data_oe), 32'd0);
        drive_edge();
        rst    = 1'b0;
        mem_wr = 1'b0;
        @(negedge clk);
        check_val("mid_after_pause", 32'(ram_pause), 32'd0);
        check_val("mid_after_oe_n", 32'(sram_oe_n), 32'd0);
        check_val("mid_after_if_data", 32'(if_data), 32'hA003);
        check_val("mid_after_rdata", 32'(mem_rdata), 32'd0);
        last_rd = 16'h0000;

        // Wait counter must restart from zero after the aborted access.
        do_access(1'b1, 1'b0, 18'h00F00, 16'h0000, 16'h5A5A, 2 + WC, 0, 16'hA003);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
